// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// mc_control : multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with a
//              variable-latency memory handshake and retired-instruction count.
//              Define ILLEGAL_TRAP_EN to trap on unknown opcodes (else NOP).
// Revision   : 1.0
// ============================================================================
module mc_control #(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             Jump,
  output logic             Jal,
  output logic             JR,
  output logic [1:0]       ALUOp,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             mem_timeout,
  output logic             trap
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX);

  localparam logic [5:0] c_op_r    = 6'b000000;
  localparam logic [5:0] c_op_lw   = 6'b100011;
  localparam logic [5:0] c_op_sw   = 6'b101011;
  localparam logic [5:0] c_op_beq  = 6'b000100;
  localparam logic [5:0] c_op_j    = 6'b000010;
  localparam logic [5:0] c_op_jal  = 6'b000011;
  localparam logic [5:0] c_op_addi = 6'b001000;
  localparam logic [5:0] c_fn_jr   = 6'b001000;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
`ifdef ILLEGAL_TRAP_EN
    , ST_TRAP = 3'd5
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [5:0]         funct_q, funct_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               timeout_q, timeout_d;
  logic               w_retire;
  logic               w_is_jr;
`ifdef ILLEGAL_TRAP_EN
  logic               trap_q, trap_d;
`endif

  function automatic logic is_known(input logic [5:0] op);
    case (op)
      c_op_r, c_op_lw, c_op_sw, c_op_beq,
      c_op_j, c_op_jal, c_op_addi: is_known = 1'b1;
      default:                     is_known = 1'b0;
    endcase
  endfunction

  assign w_is_jr = (op_q == c_op_r) && (funct_q == c_fn_jr);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    funct_d   = funct_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    w_retire  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    trap_d    = trap_q;
`endif
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        op_d    = opcode;
        funct_d = funct;
        if (is_known(opcode)) begin
          state_d = ST_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = ST_TRAP;
          trap_d  = 1'b1;
`else
          state_d  = ST_FETCH;
          w_retire = 1'b1;
`endif
        end
      end
      ST_EXEC: begin
        if ((op_q == c_op_r && !w_is_jr) || op_q == c_op_addi) begin
          state_d = ST_WB;
        end else if (op_q == c_op_lw || op_q == c_op_sw) begin
          state_d = ST_MEM;
          wait_d  = '0;
        end else begin
          state_d  = ST_FETCH;
          w_retire = 1'b1;
        end
      end
      ST_MEM: begin
        // A ready arriving in the final allowed cycle still completes normally.
        if (mem_ready) begin
          if (op_q == c_op_lw) begin
            state_d = ST_WB;
          end else begin
            state_d  = ST_FETCH;
            w_retire = 1'b1;
          end
        end else if (wait_q == WAIT_W'(MEM_WAIT_MAX - 1)) begin
          state_d   = ST_FETCH;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WB: begin
        state_d  = ST_FETCH;
        w_retire = 1'b1;
      end
      default: state_d = state_q;
    endcase
    count_d = w_retire ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      op_q      <= '0;
      funct_q   <= '0;
      wait_q    <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
`ifdef ILLEGAL_TRAP_EN
      trap_q    <= trap_d;
`endif
    end
  end

  // Controls are gated by reset directly so they drop the instant it asserts.
  always_comb begin
    pc_write = 1'b0; ir_write = 1'b0; RegDst = 1'b0; ALUSrc = 1'b0;
    MemToReg = 1'b0; RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Branch   = 1'b0; Jump = 1'b0; Jal = 1'b0; JR = 1'b0; ALUOp = 2'b00;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        ST_EXEC: begin
          case (op_q)
            c_op_r: begin
              if (w_is_jr) begin
                JR       = 1'b1;
                pc_write = 1'b1;
              end else begin
                ALUOp  = 2'b10;
                RegDst = 1'b1;
              end
            end
            c_op_addi, c_op_lw, c_op_sw: ALUSrc = 1'b1;
            c_op_beq: begin
              Branch   = 1'b1;
              ALUOp    = 2'b01;
              pc_write = zero;
            end
            c_op_j: begin
              Jump     = 1'b1;
              pc_write = 1'b1;
            end
            c_op_jal: begin
              Jump     = 1'b1;
              Jal      = 1'b1;
              RegWrite = 1'b1;
              pc_write = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          ALUSrc   = 1'b1;
          MemRead  = (op_q == c_op_lw);
          MemWrite = (op_q == c_op_sw);
        end
        ST_WB: begin
          RegWrite = 1'b1;
          RegDst   = (op_q == c_op_r);
          MemToReg = (op_q == c_op_lw);
          ALUSrc   = (op_q == c_op_lw) || (op_q == c_op_addi);
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;
  assign mem_timeout = timeout_q;
`ifdef ILLEGAL_TRAP_EN
  assign trap        = trap_q;
`else
  assign trap        = 1'b0;
`endif

endmodule
`default_nettype wire
